// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-RAM port controller, core/secondary arbitration and read-modify-write for partial stores.
// Define DMEM_ARB_RR_EN for round-robin arbitration; fixed core priority otherwise.
module dmem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  input  logic [3:0]        c_be_i,
  output logic              c_gnt_o,
  output logic              c_done_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, RD, RMW, ACK} state_t;
  localparam logic [ADDR_W-1:0] AMASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  state_t            state_q, state_d;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              rq_c, rq_d, pick_d, gnt, full, part, done, wr_full;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, lane_m, merged;
  logic [3:0]        s_be;
  assign rq_c = c_req_i & rst_n_i;
  assign rq_d = d_req_i & rst_n_i;
`ifdef DMEM_ARB_RR_EN
  logic last_c_q;
  assign pick_d = rq_d & (~rq_c | last_c_q);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) last_c_q <= 1'b0;
    else if (gnt) last_c_q <= ~pick_d;
`else
  assign pick_d = rq_d & ~rq_c;
`endif
  assign s_we    = pick_d ? d_we_i    : c_we_i;
  assign s_addr  = pick_d ? d_addr_i  : c_addr_i;
  assign s_wdata = pick_d ? d_wdata_i : c_wdata_i;
  assign s_be    = pick_d ? d_be_i    : c_be_i;
  assign full    = s_be == 4'hF;
  assign part    = s_be != 4'h0 && !full;
  assign lane_m  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign merged  = (wdata_q & lane_m) | (ram_rdata_i & ~lane_m);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        owner_q <= pick_d;
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
        be_q    <= s_be;
      end
    end
  always_comb begin
    gnt         = state_q == IDLE && (rq_c || rq_d);
    done        = state_q == RD || state_q == ACK;
    wr_full     = gnt && s_we && full;
    state_d     = gnt ? (!s_we ? RD : part ? RMW : ACK) : state_q == RMW ? ACK : IDLE;
    c_gnt_o     = gnt && !pick_d;
    d_gnt_o     = gnt && pick_d;
    c_done_o    = done && !owner_q;
    d_done_o    = done && owner_q;
    c_rdata_o   = state_q == RD && !owner_q ? ram_rdata_i : '0;
    d_rdata_o   = state_q == RD && owner_q ? ram_rdata_i : '0;
    ram_re_o    = gnt && (!s_we || part);
    ram_we_o    = rst_n_i && (wr_full || state_q == RMW);
    ram_addr_o  = state_q == RMW ? addr_q & AMASK : (ram_re_o || wr_full) ? s_addr & AMASK : '0;
    ram_wdata_o = state_q == RMW ? merged : wr_full ? s_wdata : '0;
    stall_o     = c_req_i && !c_done_o;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: vector table plus randomized transactions checked against a word-level memory model.
module tb_dmem_ctrl;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic c_req_i, c_we_i, d_req_i, d_we_i;
  logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
  logic [3:0] c_be_i, d_be_i;
  logic c_gnt_o, c_done_o, d_gnt_o, d_done_o, ram_re_o, ram_we_o, stall_o;
  logic [31:0] c_rdata_o, d_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int nvec = 0, nbad = 0;
  bit last_d = 1'b1;
  typedef struct {
    bit m;
    logic we;
    logic [31:0] addr, wdata;
    logic [3:0] be;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [10];
  always #5 clk_i = ~clk_i;
  dmem_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i), .c_be_i(c_be_i),
    .c_gnt_o(c_gnt_o), .c_done_o(c_done_o), .c_rdata_o(c_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_gnt_o(d_gnt_o), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_re_o(ram_re_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .stall_o(stall_o)
  );
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_addr_o[7:2]] <= ram_wdata_o;
    if (ram_re_o) ram_rdata_i <= mem[ram_addr_o[7:2]];
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic setm(input bit m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (m) begin d_req_i = r; d_we_i = w; d_addr_i = a; d_wdata_i = d; d_be_i = b; end
    else begin c_req_i = r; c_we_i = w; c_addr_i = a; c_wdata_i = d; c_be_i = b; end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = b[i] ? w[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
  task automatic run(input bit m, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
    int lat;
    lat = (we && be != 4'h0 && be != 4'hF) ? 2 : 1;
    setm(m, 1'b1, we, addr, wdata, be);
    @(negedge clk_i);
    chk("gnt", m ? d_gnt_o : c_gnt_o, 1);
    chk("gnt_other", m ? c_gnt_o : d_gnt_o, 0);
    chk("done_early", m ? d_done_o : c_done_o, 0);
    chk("ram_re", ram_re_o, (!we || lat == 2));
    chk("ram_we", ram_we_o, (we && be == 4'hF));
    if (!we || be != 4'h0) chk("ram_addr", ram_addr_o, addr & 32'hFFFF_FFFC);
    if (we && be == 4'hF) chk("ram_wdata", ram_wdata_o, wdata);
    if (!m) chk("stall_gnt", stall_o, 1);
    if (lat == 2) begin
      @(negedge clk_i);
      chk("rmw_we", ram_we_o, 1);
      chk("rmw_re", ram_re_o, 0);
      chk("rmw_addr", ram_addr_o, addr & 32'hFFFF_FFFC);
      chk("rmw_wdata", ram_wdata_o, exp);
      chk("rmw_done", m ? d_done_o : c_done_o, 0);
    end
    @(negedge clk_i);
    chk("done", m ? d_done_o : c_done_o, 1);
    chk("done_other", m ? c_done_o : d_done_o, 0);
    if (!we) chk("rdata", m ? d_rdata_o : c_rdata_o, exp);
    chk("rdata_other", m ? c_rdata_o : d_rdata_o, 0);
    chk("strobe_done", ram_re_o | ram_we_o, 0);
    if (!m) chk("stall_done", stall_o, 0);
    @(posedge clk_i);
    #1;
    setm(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic txn(input bit m, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int i;
    logic [31:0] e;
    i = int'(addr[7:2]);
    e = we ? merge(ref_mem[i], wdata, be) : ref_mem[i];
    run(m, we, addr, wdata, be, e);
    if (we) ref_mem[i] = e;
    last_d = m;
  endtask
  function automatic bit winner();
`ifdef DMEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b0;
`endif
  endfunction
  initial begin
    bit m, both, w;
    logic we;
    logic [31:0] a, wd, oa;
    logic [3:0] b;
    setm(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    setm(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #3;
    chk("rst_stall", stall_o, 1);
    chk("rst_c_gnt", c_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_done", c_done_o | d_done_o, 0);
    chk("rst_rdata", c_rdata_o | d_rdata_o, 0);
    chk("rst_strobe", ram_re_o | ram_we_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_wdata", ram_wdata_o, 0);
    c_req_i = 1'b0;
    #1;
    chk("rst_stall_low", stall_o, 0);
    #8 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 64; i++) txn(1, 1'b1, 32'(i * 4), $urandom, 4'hF);
    tv[0] = '{0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tv[1] = '{0, 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h11223344};
    tv[2] = '{0, 1'b0, 32'h43, 32'h0,        4'h0, 32'hDEADBEEF};
    tv[3] = '{0, 1'b1, 32'h10, 32'h00AA0000, 4'h4, 32'h11AA3344};
    tv[4] = '{0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    tv[5] = '{0, 1'b1, 32'h20, 32'h12345678, 4'h0, 32'hCAFEF00D};
    tv[6] = '{0, 1'b0, 32'h20, 32'h0,        4'h0, 32'hCAFEF00D};
    tv[7] = '{0, 1'b0, 32'h12, 32'h0,        4'h0, 32'h11AA3344};
    tv[8] = '{1, 1'b1, 32'h13, 32'hAB000000, 4'h8, 32'hABAA3344};
    tv[9] = '{1, 1'b0, 32'h11, 32'h0,        4'h0, 32'hABAA3344};
    for (int k = 0; k < 10; k++) begin
      run(tv[k].m, tv[k].we, tv[k].addr, tv[k].wdata, tv[k].be, tv[k].exp);
      if (tv[k].we) ref_mem[tv[k].addr[7:2]] = tv[k].exp;
      last_d = tv[k].m;
    end
    chk("ram_0x20", mem[8], 32'hCAFEF00D);
    setm(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    setm(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      w = winner();
      txn(w, 1'b0, w ? 32'h20 : 32'h40, 32'h0, 4'h0);
      setm(w, 1'b1, 1'b0, w ? 32'h20 : 32'h40, 32'h0, 4'h0);
    end
    setm(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setm(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int n = 0; n < 150; n++) begin
      m = 1'($urandom_range(0, 1));
      both = $urandom_range(0, 2) == 0;
      we = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255);
      wd = $urandom;
      oa = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: b = 4'hF;
        1: b = 4'h0;
        default: b = 4'($urandom);
      endcase
      if (!both) txn(m, we, a, wd, b);
      else begin
        setm(m, 1'b1, we, a, wd, b);
        setm(!m, 1'b1, 1'b0, oa, 32'h0, 4'h0);
        w = winner();
        if (w == m) begin txn(m, we, a, wd, b); txn(!m, 1'b0, oa, 32'h0, 4'h0); end
        else begin txn(!m, 1'b0, oa, 32'h0, 4'h0); txn(m, we, a, wd, b); end
      end
    end
    setm(0, 1'b1, 1'b1, 32'h10, 32'h000000FF, 4'h1);
    @(negedge clk_i);
    chk("mr_gnt", c_gnt_o, 1);
    chk("mr_re", ram_re_o, 1);
    @(posedge clk_i);
    #1;
    chk("mr_rmw_we", ram_we_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("mr_we", ram_we_o, 0);
    chk("mr_re0", ram_re_o, 0);
    chk("mr_gnts", c_gnt_o | d_gnt_o, 0);
    chk("mr_dones", c_done_o | d_done_o, 0);
    chk("mr_rdata", c_rdata_o | d_rdata_o, 0);
    chk("mr_addr", ram_addr_o, 0);
    chk("mr_wdata", ram_wdata_o, 0);
    chk("mr_stall", stall_o, 1);
    setm(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    last_d = 1'b1;
    chk("mr_mem", mem[4], ref_mem[4]);
    @(posedge clk_i);
    #1;
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    txn(1, 1'b1, 32'h10, 32'h0000BB00, 4'h2);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
